// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - read-side FIFO consumer with a two-entry output buffer
// Optional FIFO_READER_CNT_EN adds a saturating 16-bit word_count of accepted transfers.
module fifo_stream_reader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_READER_CNT_EN
  ,
  output logic [15:0]      word_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t             state, state_next;
  logic             inflight;
  logic [WIDTH-1:0] buf0, buf1, buf0_next, buf1_next;
  logic             pop;
  logic [2:0]       load;

  assign m_valid = (state != EMPTY);
  assign m_data  = buf0;
  assign pop     = m_valid && m_ready;

  // Words already committed (buffered plus in flight) must leave room for one more.
  assign load       = 3'(state) + 3'(inflight);
  assign fifo_rd_en = !rst && !fifo_empty && (load <= 3'd1 + 3'(pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      inflight <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      state    <= state_next;
      inflight <= fifo_rd_en;
      buf0     <= buf0_next;
      buf1     <= buf1_next;
    end
  end

  // buf0 is always the head; buf1 only ever holds the second-oldest word.
  always_comb begin
    state_next = state;
    buf0_next  = buf0;
    buf1_next  = buf1;
    case (state)
      EMPTY: begin
        if (inflight) begin
          state_next = ONE;
          buf0_next  = fifo_rd_data;
        end
      end
      ONE: begin
        if (inflight && pop) begin
          buf0_next = fifo_rd_data;
        end else if (inflight) begin
          state_next = TWO;
          buf1_next  = fifo_rd_data;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_next = ONE;
          buf0_next  = buf1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

`ifdef FIFO_READER_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count <= 16'd0;
    end else if (pop && (word_count != 16'hFFFF)) begin
      word_count <= word_count + 16'd1;
    end
  end
`endif

endmodule
